ram_access_ctrl: RTL and testbench

RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

---
 rtl/ram_access_pkg.sv | 21 ++
 rtl/ram_access_ctrl_edge_detect.sv | 25 ++
 rtl/ram_access_ctrl.sv | 175 +++++++++++++++++
 tb/tb_ram_access_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_access_pkg.sv
// Shared constants and FSM state encoding for the RAM access controller.
package ram_access_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 4;
  localparam int RAM_DEPTH  = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_READ      = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_CLEAR     = 3'd4,
    ST_SCAN_WAIT = 3'd5
  } state_e;

  function automatic logic state_busy(input state_e s);
    return (s == ST_WRITE) || (s == ST_READ) || (s == ST_CAPTURE) || (s == ST_CLEAR);
  endfunction

endpackage

// File: rtl/ram_access_ctrl_edge_detect.sv
// Registers a level request and emits a one-cycle pulse on its 0->1 transition.
module edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic level_q;
  logic level_qq;

  // Both stages load 1 so a request already high at reset release is not seen as an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      level_q  <= 1'b1;
      level_qq <= 1'b1;
    end else begin
      level_q  <= level;
      level_qq <= level_q;
    end
  end

  assign pulse = level_q & ~level_qq;

endmodule

// File: rtl/ram_access_ctrl.sv
// Manual write/read/clear front-end for a small registered-address RAM.
// Defining RAM_ACCESS_CTRL_SCAN_EN adds a periodic auto-scan read mode.
module ram_access_ctrl
  import ram_access_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SCAN_DIV = 50000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              clr_req,
  input  logic              scan_en,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

  state_e state;
  state_e rest_state;
  logic   wr_edge;
  logic   rd_edge;
  logic   clr_edge;

  edge_detect u_wr_edge  (.clock(clock), .reset(reset), .level(wr_req),  .pulse(wr_edge));
  edge_detect u_rd_edge  (.clock(clock), .reset(reset), .level(rd_req),  .pulse(rd_edge));
  edge_detect u_clr_edge (.clock(clock), .reset(reset), .level(clr_req), .pulse(clr_edge));

  assign busy      = state_busy(state);
  assign dbg_state = state;

`ifdef RAM_ACCESS_CTRL_SCAN_EN
  localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);

  logic [TICK_W-1:0] tick;
  logic [ADDR_W-1:0] scan_addr;
  logic              scan_rd;
  logic              scan_hit;
  logic              manual_edge;

  assign scan_hit    = (tick == TICK_LAST);
  assign manual_edge = clr_edge | wr_edge | rd_edge;

  // The tick keeps running through a scan-initiated read so reads stay SCAN_DIV apart,
  // but freezes during any manually requested operation.
  always_ff @(posedge clock) begin
    if (reset) begin
      tick      <= '0;
      scan_addr <= '0;
      scan_rd   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          tick    <= '0;
          scan_rd <= 1'b0;
        end
        ST_SCAN_WAIT: begin
          scan_rd <= 1'b0;
          if (!manual_edge && scan_en) begin
            if (scan_hit) begin
              tick      <= '0;
              scan_rd   <= 1'b1;
              scan_addr <= (scan_addr == LAST_ADDR) ? '0 : scan_addr + 1'b1;
            end else begin
              tick <= tick + 1'b1;
            end
          end
        end
        ST_READ, ST_CAPTURE: begin
          if (scan_rd && !scan_hit) tick <= tick + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rest_state = ST_IDLE;
    if (scan_en) rest_state = ST_SCAN_WAIT;
  end
`else
  logic unused_scan_en;
  localparam int unused_scan_div = SCAN_DIV;
  assign unused_scan_en = scan_en;

  always_comb begin
    rest_state = ST_IDLE;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      ram_addr   <= '0;
      ram_data   <= '0;
      ram_wren   <= 1'b0;
      disp_addr  <= '0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
    end else begin
      disp_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_SCAN_WAIT: begin
          if (clr_edge) begin
            state    <= ST_CLEAR;
            ram_addr <= '0;
            ram_data <= '0;
            ram_wren <= 1'b1;
          end else if (wr_edge) begin
            state    <= ST_WRITE;
            ram_addr <= addr_in;
            ram_data <= data_in;
            ram_wren <= 1'b1;
          end else if (rd_edge) begin
            state    <= ST_READ;
            ram_addr <= addr_in;
          end else begin
`ifdef RAM_ACCESS_CTRL_SCAN_EN
            if (state == ST_SCAN_WAIT) begin
              if (!scan_en) begin
                state <= ST_IDLE;
              end else if (scan_hit) begin
                state    <= ST_READ;
                ram_addr <= scan_addr;
              end
            end else if (scan_en) begin
              state <= ST_SCAN_WAIT;
            end
`endif
          end
        end
        // ram_addr is left on the written address so READ performs the read-back.
        ST_WRITE: begin
          ram_wren <= 1'b0;
          state    <= ST_READ;
        end
        ST_READ: begin
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          disp_data  <= ram_q;
          disp_addr  <= ram_addr;
          disp_valid <= 1'b1;
          state      <= rest_state;
        end
        ST_CLEAR: begin
          if (ram_addr == LAST_ADDR) begin
            ram_wren <= 1'b0;
            state    <= rest_state;
          end else begin
            ram_addr <= ram_addr + 1'b1;
          end
        end
        default: begin
          ram_wren <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed self-checking bench for ram_access_ctrl with a behavioural 32x4 RAM.
module tb_ram_access_ctrl;

  logic       clock;
  logic       reset;
  logic       wr_req, rd_req, clr_req, scan_en;
  logic [4:0] addr_in;
  logic [3:0] data_in;
  logic [3:0] ram_q;
  logic [4:0] ram_addr;
  logic [3:0] ram_data;
  logic       ram_wren;
  logic [4:0] disp_addr;
  logic [3:0] disp_data;
  logic       disp_valid;
  logic       busy;
  logic [2:0] dbg_state;

  ram_access_ctrl #(.ADDR_W(5), .DATA_W(4), .SCAN_DIV(4)) dut (
    .clock(clock), .reset(reset),
    .wr_req(wr_req), .rd_req(rd_req), .clr_req(clr_req), .scan_en(scan_en),
    .addr_in(addr_in), .data_in(data_in), .ram_q(ram_q),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
    .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset and RAM model
  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [3:0] mem [32];
  logic [4:0] addr_q;
  assign ram_q = mem[addr_q];

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= 4'h0;
    end else if (ram_wren) begin
      mem[ram_addr] <= ram_data;
    end
    addr_q <= ram_addr;
  end

  // scoreboard
  logic [8:0] exp_q [$];
  int         vcyc_q [$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int wren_cnt = 0;
  int valid_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic [8:0] exp_w;
    @(posedge clock);
    #1;
    cyc++;
    if (ram_wren) wren_cnt++;
    if (disp_valid) begin
      valid_cnt++;
      vcyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("disp_unexpected", {31'd0, disp_valid}, 32'd0);
      end else begin
        exp_w = exp_q.pop_front();
        check("disp_addr_data", {23'd0, disp_addr, disp_data}, {23'd0, exp_w});
      end
    end
  endtask

`ifdef RAM_ACCESS_CTRL_SCAN_EN
  logic [3:0] exp_mem [32];

  task automatic do_write(input logic [4:0] a, input logic [3:0] d);
    addr_in = a;
    data_in = d;
    wr_req  = 1'b1;
    exp_q.push_back({a, d});
    exp_mem[a] = d;
    repeat (2) step();
    wr_req = 1'b0;
    repeat (6) step();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int clr_idx, clr_err, first_c, last_c, k;
    reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0; clr_req = 1'b0; scan_en = 1'b0;
    addr_in = '0; data_in = '0;
    repeat (3) step();
    check("rst_wren", {31'd0, ram_wren}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_valid", {31'd0, disp_valid}, 0);
    check("rst_ram_addr", {27'd0, ram_addr}, 0);
    check("rst_state", {29'd0, dbg_state}, 0);

    // request held through reset must not fire
    wr_req = 1'b1;
    step();
    reset = 1'b0;
    wren_cnt = 0;
    repeat (4) step();
    check("held_rst_wren", wren_cnt, 0);
    check("held_rst_state", {29'd0, dbg_state}, 0);
    wr_req = 1'b0;
    repeat (2) step();

    // write 0xA to address 5 with read-back
    wren_cnt = 0;
    addr_in = 5'd5; data_in = 4'hA; wr_req = 1'b1;
    exp_q.push_back({5'd5, 4'hA});
    step();
    check("wr_wren_early", {31'd0, ram_wren}, 0);
    step();
    check("wr_wren_n1", {31'd0, ram_wren}, 1);
    check("wr_addr", {27'd0, ram_addr}, 5);
    check("wr_data", {28'd0, ram_data}, 4'hA);
    check("wr_busy", {31'd0, busy}, 1);
    check("wr_state", {29'd0, dbg_state}, 1);
    step();
    check("wr_wren_n2", {31'd0, ram_wren}, 0);
    step();
    check("wr_valid_n3", {31'd0, disp_valid}, 0);
    step();
    check("wr_valid_n4", {31'd0, disp_valid}, 1);
    step();
    check("wr_valid_n5", {31'd0, disp_valid}, 0);
    check("wr_busy_done", {31'd0, busy}, 0);
    wr_req = 1'b0;
    repeat (5) step();
    check("wr_wren_count", wren_cnt, 1);

    // rd held high for 10 cycles gives one read
    valid_cnt = 0;
    addr_in = 5'd5; rd_req = 1'b1;
    exp_q.push_back({5'd5, 4'hA});
    repeat (2) step();
    check("rd_state", {29'd0, dbg_state}, 2);
    step();
    check("rd_valid_n2", {31'd0, disp_valid}, 0);
    step();
    check("rd_valid_n3", {31'd0, disp_valid}, 1);
    repeat (6) step();
    rd_req = 1'b0;
    repeat (3) step();
    check("rd_held_pulses", valid_cnt, 1);

    // wr and rd together: write wins, rd edge during busy is ignored
    wren_cnt = 0; valid_cnt = 0;
    addr_in = 5'd9; data_in = 4'h3; wr_req = 1'b1; rd_req = 1'b1;
    exp_q.push_back({5'd9, 4'h3});
    repeat (2) step();
    check("pri_state", {29'd0, dbg_state}, 1);
    rd_req = 1'b0;
    step();
    rd_req = 1'b1;
    repeat (8) step();
    wr_req = 1'b0; rd_req = 1'b0;
    repeat (3) step();
    check("pri_wren_count", wren_cnt, 1);
    check("pri_valid_count", valid_cnt, 1);

    // clear: 32 consecutive zero writes in ascending order
    clr_idx = 0; clr_err = 0; first_c = -1; last_c = -1;
    clr_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 2) clr_req = 1'b0;
      if (ram_wren) begin
        if (ram_addr != clr_idx[4:0] || ram_data != 4'h0) clr_err++;
        clr_idx++;
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
      end
    end
    check("clr_wren_cycles", clr_idx, 32);
    check("clr_order_errors", clr_err, 0);
    check("clr_contiguous", last_c - first_c + 1, 32);
    check("clr_end_state", {29'd0, dbg_state}, 0);
    valid_cnt = 0;
    addr_in = 5'd5; rd_req = 1'b1;
    exp_q.push_back({5'd5, 4'h0});
    repeat (6) step();
    rd_req = 1'b0;
    repeat (2) step();
    check("clr_read_pulses", valid_cnt, 1);

    // reset during the 10th clear cycle aborts the clear
    clr_req = 1'b1;
    k = 0;
    while (!ram_wren && k < 5) begin
      step();
      k++;
    end
    check("clr2_start", {31'd0, ram_wren}, 1);
    repeat (9) step();
    check("clr2_cycle10_addr", {27'd0, ram_addr}, 9);
    reset = 1'b1;
    step();
    check("abort_wren", {31'd0, ram_wren}, 0);
    check("abort_ram_addr", {27'd0, ram_addr}, 0);
    check("abort_ram_data", {28'd0, ram_data}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_disp_addr", {27'd0, disp_addr}, 0);
    check("abort_disp_data", {28'd0, disp_data}, 0);
    check("abort_state", {29'd0, dbg_state}, 0);
    reset = 1'b0;
    wren_cnt = 0;
    repeat (4) step();
    check("abort_no_retrigger", wren_cnt, 0);
    clr_req = 1'b0;
    repeat (2) step();

`ifdef RAM_ACCESS_CTRL_SCAN_EN
    // auto-scan wraps 30, 31, 0 with reads 4 cycles apart
    for (int i = 0; i < 32; i++) exp_mem[i] = 4'h0;
    do_write(5'd30, 4'h7);
    do_write(5'd31, 4'h8);
    do_write(5'd0, 4'h1);
    for (int i = 0; i < 33; i++) exp_q.push_back({i[4:0], exp_mem[i % 32]});
    valid_cnt = 0;
    vcyc_q.delete();
    scan_en = 1'b1;
    k = 0;
    while (valid_cnt < 33 && k < 400) begin
      step();
      k++;
    end
    check("scan_reads", valid_cnt, 33);
    if (vcyc_q.size() == 33) begin
      check("scan_gap_30_31", vcyc_q[31] - vcyc_q[30], 4);
      check("scan_gap_31_0", vcyc_q[32] - vcyc_q[31], 4);
    end
    scan_en = 1'b0;
    repeat (4) step();
    check("scan_off_state", {29'd0, dbg_state}, 0);
    check("scan_off_busy", {31'd0, busy}, 0);
`else
    // without the scan feature, scan_en has no effect
    valid_cnt = 0;
    scan_en = 1'b1;
    repeat (20) step();
    check("noscan_valid", valid_cnt, 0);
    check("noscan_state", {29'd0, dbg_state}, 0);
    check("noscan_busy", {31'd0, busy}, 0);
    scan_en = 1'b0;
    step();
`endif

    check("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
